// File: rtl/functf_speed_mc_pkg.sv
// rtl/functf_speed_mc_pkg.sv - shared rate encodings and state widths for the speed-control front end
package functf_speed_mc_pkg;

  typedef enum logic [1:0] {
    RATE_40K = 2'd0,
    RATE_32K = 2'd1,
    RATE_24K = 2'd2,
    RATE_16K = 2'd3
  } rate_e;

  localparam int DMS_W = 12;
  localparam int DML_W = 14;
  localparam int FI_W  = 3;

endpackage

// File: rtl/functf_lut.sv
// rtl/functf_lut.sv - combinational quantizer output to F(I) map, shared with the decoder
module functf_lut
  import functf_speed_mc_pkg::*;
(
  input  logic [4:0]      I,
  input  logic [1:0]      RATE,
  output logic [FI_W-1:0] FI
);

  logic [3:0] im;

  // The N-bit one's complement of a negative code drops its sign bit into the magnitude.
  always_comb begin
    im = '0;
    FI = '0;
    case (RATE)
      RATE_16K: im = {3'b000, I[1] ? ~I[0]   : I[0]};
      RATE_24K: im = {2'b00,  I[2] ? ~I[1:0] : I[1:0]};
      RATE_32K: im = {1'b0,   I[3] ? ~I[2:0] : I[2:0]};
      default:  im = I[4] ? ~I[3:0] : I[3:0];
    endcase
    case (RATE)
      RATE_16K: FI = (im == 4'd1) ? 3'd7 : 3'd0;
      RATE_24K: begin
        case (im)
          4'd3:    FI = 3'd7;
          4'd2:    FI = 3'd2;
          4'd1:    FI = 3'd1;
          default: FI = 3'd0;
        endcase
      end
      RATE_32K: begin
        case (im)
          4'd7:              FI = 3'd7;
          4'd6:              FI = 3'd3;
          4'd5, 4'd4, 4'd3:  FI = 3'd1;
          default:           FI = 3'd0;
        endcase
      end
      default: begin
        case (im)
          4'd15, 4'd14:                  FI = 3'd6;
          4'd13:                         FI = 3'd5;
          4'd12:                         FI = 3'd4;
          4'd11:                         FI = 3'd3;
          4'd10:                         FI = 3'd2;
          4'd9, 4'd8, 4'd7, 4'd6, 4'd5:  FI = 3'd1;
          default:                       FI = 3'd0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/functf_speed_mc.sv
// rtl/functf_speed_mc.sv - multi-channel F(I) mapping with per-channel DMS/DML averaging
module functf_speed_mc
  import functf_speed_mc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHW-1:0]    in_ch,
  input  logic [4:0]        I,
  input  logic [1:0]        RATE,
  input  logic              clr,
  input  logic [CHW-1:0]    clr_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHW-1:0]    out_ch,
  output logic [FI_W-1:0]   FI,
  output logic [DMS_W-1:0]  DMSP,
  output logic [DML_W-1:0]  DMLP
);

  logic [FI_W-1:0]  lut_fi;
  logic             s1_valid;
  logic [CHW-1:0]   s1_ch;
  logic [FI_W-1:0]  s1_fi;
  logic [DMS_W-1:0] dms [NCH];
  logic [DML_W-1:0] dml [NCH];
  logic             accept;
  logic             load;
  logic [DMS_W-1:0] dms_cur, difsx_a, dmsp_nxt;
  logic [DML_W-1:0] dml_cur, difsx_b, dmlp_nxt;
  logic [12:0]      dif_a;
  logic [14:0]      dif_b;

  functf_lut u_lut (
    .I    (I),
    .RATE (RATE),
    .FI   (lut_fi)
  );

  function automatic logic ch_ok(input logic [CHW-1:0] ch);
    return 32'(ch) < 32'(NCH);
  endfunction

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = s1_valid && (!out_valid || out_ready);

  // Write-back shares the output-load edge, so the array read here is always current.
  always_comb begin
    dms_cur  = ch_ok(s1_ch) ? dms[s1_ch] : '0;
    dml_cur  = ch_ok(s1_ch) ? dml[s1_ch] : '0;
    dif_a    = {1'b0, s1_fi, 9'b0} - {1'b0, dms_cur};
    difsx_a  = dif_a[12] ? {4'hF, dif_a[12:5]} : {4'h0, dif_a[12:5]};
    dmsp_nxt = difsx_a + dms_cur;
    dif_b    = {1'b0, s1_fi, 11'b0} - {1'b0, dml_cur};
    difsx_b  = dif_b[14] ? {6'h3F, dif_b[14:7]} : {6'h00, dif_b[14:7]};
    dmlp_nxt = difsx_b + dml_cur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_fi    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_ch    <= in_ch;
      s1_fi    <= lut_fi;
    end else if (load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      FI        <= '0;
      DMSP      <= '0;
      DMLP      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_ch    <= s1_ch;
      FI        <= s1_fi;
      DMSP      <= dmsp_nxt;
      DMLP      <= dmlp_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The clear is ordered after the write-back so it wins on a shared edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        dms[k] <= '0;
        dml[k] <= '0;
      end
    end else begin
      if (load && ch_ok(s1_ch)) begin
        dms[s1_ch] <= dmsp_nxt;
        dml[s1_ch] <= dmlp_nxt;
      end
      if (clr && ch_ok(clr_ch)) begin
        dms[clr_ch] <= '0;
        dml[clr_ch] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_functf_speed_mc.sv
// tb/tb_functf_speed_mc.sv - randomized and directed checks against a behavioural G.726 model
module tb_functf_speed_mc;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic [4:0]     I = '0;
  logic [1:0]     RATE = '0;
  logic           clr = 1'b0;
  logic [CHW-1:0] clr_ch = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [CHW-1:0] out_ch;
  logic [2:0]     FI;
  logic [11:0]    DMSP;
  logic [13:0]    DMLP;

  functf_speed_mc #(.NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .I(I), .RATE(RATE), .clr(clr), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .FI(FI), .DMSP(DMSP), .DMLP(DMLP)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {int ch; int fi; int dmsp; int dmlp;} res_t;
  res_t expq[$];
  int   m_dms[NCH];
  int   m_dml[NCH];
  bit   held = 0;
  logic [31:0] h_ch, h_fi, h_dmsp, h_dmlp;

  function automatic int ref_fi(input int code, input int rate);
    int n, full, half, im;
    n    = 5 - rate;
    full = code % (1 << n);
    half = 1 << (n - 1);
    im   = (full >= half) ? (((1 << n) - 1 - full) % half) : (full % half);
    case (rate)
      3: return (im == 1) ? 7 : 0;
      2: return (im == 3) ? 7 : (im == 2) ? 2 : (im == 1) ? 1 : 0;
      1: return (im == 7) ? 7 : (im == 6) ? 3 : (im >= 3 && im <= 5) ? 1 : 0;
      default: begin
        if (im >= 14) return 6;
        if (im >= 10) return im - 8;
        if (im >= 5) return 1;
        return 0;
      end
    endcase
  endfunction

  task automatic model_accept(input int ch, input int code, input int rate);
    res_t r;
    int dms, dml, dif, difsx;
    dms = (ch < NCH) ? m_dms[ch] : 0;
    dml = (ch < NCH) ? m_dml[ch] : 0;
    r.ch = ch;
    r.fi = ref_fi(code, rate);
    dif = ((r.fi * 512) + 8192 - dms) % 8192;
    difsx = (dif >= 4096) ? (dif / 32) + 3840 : dif / 32;
    r.dmsp = (difsx + dms) % 4096;
    dif = ((r.fi * 2048) + 32768 - dml) % 32768;
    difsx = (dif >= 16384) ? (dif / 128) + 16128 : dif / 128;
    r.dmlp = (difsx + dml) % 16384;
    if (ch < NCH) begin
      m_dms[ch] = r.dmsp;
      m_dml[ch] = r.dmlp;
    end
    expq.push_back(r);
  endtask

  // Entered and left at a falling edge so outputs are sampled away from the active edge.
  task automatic tick(input bit iv, input int ch, input int code, input int rate,
                      input bit ordy, input bit c, input int cch);
    res_t e;
    if (held) begin
      check("hold_valid", out_valid, 1);
      check("hold_ch", out_ch, h_ch);
      check("hold_fi", FI, h_fi);
      check("hold_dmsp", DMSP, h_dmsp);
      check("hold_dmlp", DMLP, h_dmlp);
    end
    out_ready = ordy;
    in_valid  = iv;
    in_ch     = CHW'(ch);
    I         = 5'(code);
    RATE      = 2'(rate);
    clr       = c;
    clr_ch    = CHW'(cch);
    #1;
    if (out_valid && ordy) begin
      if (expq.size() == 0) begin
        check("extra_output", 1, 0);
      end else begin
        e = expq.pop_front();
        check("out_ch", out_ch, e.ch);
        check("out_fi", FI, e.fi);
        check("out_dmsp", DMSP, e.dmsp);
        check("out_dmlp", DMLP, e.dmlp);
      end
    end
    held = out_valid && !ordy;
    if (held) begin
      h_ch = out_ch; h_fi = FI; h_dmsp = DMSP; h_dmlp = DMLP;
    end
    if (c && cch < NCH) begin
      m_dms[cch] = 0;
      m_dml[cch] = 0;
    end
    if (iv && in_ready) model_accept(ch, code, rate);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    clr = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ch", out_ch, 0);
    check("rst_fi", FI, 0);
    check("rst_dmsp", DMSP, 0);
    check("rst_dmlp", DMLP, 0);
    for (int k = 0; k < NCH; k++) begin
      m_dms[k] = 0;
      m_dml[k] = 0;
    end
    expq.delete();
    held = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic probe(input int ch, input int code, input int rate, input int exp_fi,
                       input string tag);
    tick(1, ch, code, rate, 1, 0, 0);
    idle();
    check(tag, FI, exp_fi);
    idle();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    tick(1, 0, 7, 1, 1, 0, 0);
    check("lat_not_yet", out_valid, 0);
    tick(1, 0, 7, 1, 1, 0, 0);
    check("lat_valid", out_valid, 1);
    check("first_fi", FI, 7);
    check("first_dmsp", DMSP, 112);
    check("first_dmlp", DMLP, 112);
    idle();
    check("b2b_dmsp", DMSP, 220);
    check("b2b_dmlp", DMLP, 223);
    idle();

    do_reset();
    tick(1, 0, 7, 1, 1, 0, 0);
    idle();
    idle();
    tick(1, 0, 0, 1, 1, 0, 0);
    idle();
    check("neg_fi", FI, 0);
    check("neg_dmsp", DMSP, 108);
    check("neg_dmlp", DMLP, 111);
    idle();

    probe(1, 5'h10, 0, 6, "fi_r40_i10");
    probe(1, 5'h0F, 0, 6, "fi_r40_i0f");
    probe(2, 2, 3, 7, "fi_r16_i2");
    probe(3, 5, 2, 2, "fi_r24_i5");

    tick(1, 0, 7, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 1, 1, 0);
    tick(1, 0, 7, 1, 1, 0, 0);
    idle();
    check("clr_dmsp", DMSP, 112);
    check("clr_dmlp", DMLP, 112);
    idle();

    for (int n = 0; n < 500; n++)
      tick($urandom_range(0, 99) < 70, $urandom_range(0, 2), $urandom_range(0, 31),
           $urandom_range(0, 3), $urandom_range(0, 99) < 60, 0, 0);

    for (int n = 0; n < 4; n++)
      tick(1, $urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 3), 0, 0, 0);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick(1, c, 7, 1, 1, 0, 0);
      idle();
      check("post_rst_dmsp", DMSP, 112);
      check("post_rst_dmlp", DMLP, 112);
      idle();
    end

    for (int n = 0; n < 300; n++)
      tick($urandom_range(0, 99) < 80, $urandom_range(0, 3), $urandom_range(0, 31),
           $urandom_range(0, 3), $urandom_range(0, 99) < 50, 0, 0);

    for (int k = 0; k < 20 && expq.size() > 0; k++) idle();
    check("drain_empty", expq.size(), 0);
    check("drain_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
